// File: rtl/fsm_flow_ctrl_n_pkg.sv
// rtl/fsm_flow_ctrl_n_pkg.sv - shared state encoding and widths for the flow-control FSM
// Package fsm_flow_pkg: state codes (3-bit) seen on oState and the error counter width.
package fsm_flow_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/fsm_flow_ctrl_n_if.sv
// rtl/fsm_flow_ctrl_n_if.sv - status/control bundle between FIFO bank, flow FSM and arbiter
// Optional macro FSM_ERR_RECOVER_EN adds oErrCnt.
// master: environment side (drives sInit/sEmpty/sFull/sPause/sContinue/sThresh*, reads o*)
// slave : flow FSM side (reads s*, drives oState/oThresh*/oPauseMask/oErrChan/oIdle/oError)
interface fsm_flow_ctrl_n_if
  import fsm_flow_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TW   = 4
);
  logic            sInit;
  logic [N_CH-1:0] sEmpty;
  logic [N_CH-1:0] sFull;
  logic [N_CH-1:0] sPause;
  logic [N_CH-1:0] sContinue;
  logic [TW-1:0]   sThreshLow;
  logic [TW-1:0]   sThreshHigh;
  logic [2:0]      oState;
  logic [TW-1:0]   oThreshLow;
  logic [TW-1:0]   oThreshHigh;
  logic [N_CH-1:0] oPauseMask;
  logic [N_CH-1:0] oErrChan;
  logic            oIdle;
  logic            oError;
`ifdef FSM_ERR_RECOVER_EN
  logic [ERR_CNT_W-1:0] oErrCnt;

  modport master (
    output sInit, sEmpty, sFull, sPause, sContinue, sThreshLow, sThreshHigh,
    input  oState, oThreshLow, oThreshHigh, oPauseMask, oErrChan, oIdle, oError, oErrCnt
  );
  modport slave (
    input  sInit, sEmpty, sFull, sPause, sContinue, sThreshLow, sThreshHigh,
    output oState, oThreshLow, oThreshHigh, oPauseMask, oErrChan, oIdle, oError, oErrCnt
  );
`else
  modport master (
    output sInit, sEmpty, sFull, sPause, sContinue, sThreshLow, sThreshHigh,
    input  oState, oThreshLow, oThreshHigh, oPauseMask, oErrChan, oIdle, oError
  );
  modport slave (
    input  sInit, sEmpty, sFull, sPause, sContinue, sThreshLow, sThreshHigh,
    output oState, oThreshLow, oThreshHigh, oPauseMask, oErrChan, oIdle, oError
  );
`endif
endinterface

// File: rtl/fsm_flow_ctrl_n_pause_tracker.sv
// rtl/fsm_flow_ctrl_n_pause_tracker.sv - per-channel pause mask register
// Ports: clk, rst_n (async active-low), state/next_state (FSM), pause/cont (per-channel
// requests), pause_mask (registered mask), any_paused (new mask would be non-zero).
module fsm_pause_tracker
  import fsm_flow_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  state_e          state,
  input  state_e          next_state,
  input  logic [N_CH-1:0] pause,
  input  logic [N_CH-1:0] cont,
  output logic [N_CH-1:0] pause_mask,
  output logic            any_paused
);

  logic [N_CH-1:0] nm;

  // In PAUSE the held mask accumulates new requests; a resume on a bit wins over a pause.
  always_comb begin
    nm = pause & ~cont;
    if (state == ST_PAUSE) begin
      nm = (pause_mask | pause) & ~cont;
    end
  end

  assign any_paused = |nm;

  // Only PAUSE holds a non-zero mask; every other destination clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_mask <= '0;
    end else if (next_state == ST_PAUSE) begin
      pause_mask <= nm;
    end else begin
      pause_mask <= '0;
    end
  end

endmodule

// File: rtl/fsm_flow_ctrl_n.sv
// rtl/fsm_flow_ctrl_n.sv - N-channel FIFO flow-control FSM with watermark latch and error capture
// Optional macro FSM_ERR_RECOVER_EN: ERROR exits to INIT on sInit and oErrCnt counts entries.
// Ports: CLK (rising edge), sReset (async active-low), bus (fsm_flow_ctrl_n_if.slave):
// status/requests in, registered state, thresholds, pause mask, error mask and flags out.
module fsm_flow_ctrl_n
  import fsm_flow_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int TW       = 4,
  parameter int LOW_DEF  = 1,
  parameter int HIGH_DEF = 14
) (
  input logic          CLK,
  input logic          sReset,
  fsm_flow_ctrl_n_if.slave bus
);

  state_e          state, next_state;
  logic            any_paused;
  logic [TW-1:0]   thresh_low, thresh_high;
  logic [N_CH-1:0] err_chan;
  logic            idle_q, error_q;
  logic            any_full;
  logic            all_empty;

  assign any_full  = |bus.sFull;
  assign all_empty = &bus.sEmpty;

  fsm_pause_tracker #(.N_CH(N_CH)) u_pause (
    .clk        (CLK),
    .rst_n      (sReset),
    .state      (state),
    .next_state (next_state),
    .pause      (bus.sPause),
    .cont       (bus.sContinue),
    .pause_mask (bus.oPauseMask),
    .any_paused (any_paused)
  );

  always_ff @(posedge CLK or negedge sReset) begin
    if (!sReset) begin
      state <= ST_RESET;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RESET:  next_state = ST_INIT;
      ST_INIT:   if (!bus.sInit) next_state = ST_IDLE;
      ST_IDLE: begin
        if (any_full)        next_state = ST_ERROR;
        else if (bus.sInit)  next_state = ST_INIT;
        else if (!all_empty) next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_full)        next_state = ST_ERROR;
        else if (bus.sInit)  next_state = ST_INIT;
        else if (any_paused) next_state = ST_PAUSE;
        else if (all_empty)  next_state = ST_IDLE;
      end
      ST_PAUSE: begin
        if (any_full)         next_state = ST_ERROR;
        else if (bus.sInit)   next_state = ST_INIT;
        else if (!any_paused) next_state = ST_ACTIVE;
      end
      ST_ERROR: begin
`ifdef FSM_ERR_RECOVER_EN
        if (bus.sInit) next_state = ST_INIT;
`endif
      end
      default:   next_state = ST_RESET;
    endcase
  end

  // Thresholds only load as a consistent pair; an inverted pair is dropped.
  always_ff @(posedge CLK or negedge sReset) begin
    if (!sReset) begin
      thresh_low  <= TW'(LOW_DEF);
      thresh_high <= TW'(HIGH_DEF);
    end else if (state == ST_INIT && !(bus.sThreshLow > bus.sThreshHigh)) begin
      thresh_low  <= bus.sThreshLow;
      thresh_high <= bus.sThreshHigh;
    end
  end

  // Error mask is a snapshot of the entry edge only.
  always_ff @(posedge CLK or negedge sReset) begin
    if (!sReset) begin
      err_chan <= '0;
    end else if (next_state == ST_ERROR && state != ST_ERROR) begin
      err_chan <= bus.sFull;
    end else if (state == ST_ERROR && next_state == ST_INIT) begin
      err_chan <= '0;
    end
  end

  always_ff @(posedge CLK or negedge sReset) begin
    if (!sReset) begin
      idle_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      idle_q  <= (next_state == ST_IDLE);
      error_q <= (next_state == ST_ERROR);
    end
  end

`ifdef FSM_ERR_RECOVER_EN
  logic [ERR_CNT_W-1:0] err_cnt;

  always_ff @(posedge CLK or negedge sReset) begin
    if (!sReset) begin
      err_cnt <= '0;
    end else if (next_state == ST_ERROR && state != ST_ERROR && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.oErrCnt = err_cnt;
`endif

  assign bus.oState      = state;
  assign bus.oThreshLow  = thresh_low;
  assign bus.oThreshHigh = thresh_high;
  assign bus.oErrChan    = err_chan;
  assign bus.oIdle       = idle_q;
  assign bus.oError      = error_q;

endmodule

// File: tb/tb_fsm_flow_ctrl_n.sv
// tb/tb_fsm_flow_ctrl_n.sv - scoreboard bench for fsm_flow_ctrl_n (N_CH=4, TW=4)
module tb_fsm_flow_ctrl_n;

  logic CLK;
  logic sReset;
  int   n_checks = 0;
  int   n_errors = 0;

  fsm_flow_ctrl_n_if #(.N_CH(4), .TW(4)) bus ();

  fsm_flow_ctrl_n #(.N_CH(4), .TW(4), .LOW_DEF(1), .HIGH_DEF(14)) dut (
    .CLK    (CLK),
    .sReset (sReset),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [3:0] tl;
    logic [3:0] th;
    logic [3:0] pm;
    logic [3:0] ec;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    check({e.tag, ".state"}, 32'(bus.oState), 32'(e.st));
    check({e.tag, ".tlow"}, 32'(bus.oThreshLow), 32'(e.tl));
    check({e.tag, ".thigh"}, 32'(bus.oThreshHigh), 32'(e.th));
    check({e.tag, ".pmask"}, 32'(bus.oPauseMask), 32'(e.pm));
    check({e.tag, ".errchan"}, 32'(bus.oErrChan), 32'(e.ec));
    check({e.tag, ".idle"}, 32'(bus.oIdle), 32'(e.st == 3'd2));
    check({e.tag, ".error"}, 32'(bus.oError), 32'(e.st == 3'd5));
`ifdef FSM_ERR_RECOVER_EN
    check({e.tag, ".errcnt"}, 32'(bus.oErrCnt), 32'(e.cnt));
`endif
  endtask

  // Inputs are already driven; record the expectation, clock once, then score it.
  task automatic step(input string tag, input logic [2:0] st, input logic [3:0] tl,
                      input logic [3:0] th, input logic [3:0] pm, input logic [3:0] ec,
                      input logic [7:0] cnt);
    exp_t e;
    e.tag = tag; e.st = st; e.tl = tl; e.th = th; e.pm = pm; e.ec = ec; e.cnt = cnt;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      compare_outputs(sb.pop_front());
    end
  endtask

  task automatic check_reset_values(input string tag);
    exp_t e;
    e.tag = tag; e.st = 3'd0; e.tl = 4'd1; e.th = 4'd14; e.pm = 4'd0; e.ec = 4'd0; e.cnt = 8'd0;
    compare_outputs(e);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  initial begin
    sReset = 1'b0;
    bus.sInit = 1'b1; bus.sEmpty = 4'hF; bus.sFull = 4'h0;
    bus.sPause = 4'h0; bus.sContinue = 4'h0;
    bus.sThreshLow = 4'd3; bus.sThreshHigh = 4'd12;

    // Bring-up
    #12;
    check_reset_values("rst");
    #2 sReset = 1'b1;
    step("to_init", 3'd1, 4'd1, 4'd14, 4'h0, 4'h0, 8'd0);
    step("init_ld", 3'd1, 4'd3, 4'd12, 4'h0, 4'h0, 8'd0);
    bus.sInit = 1'b0;
    step("to_idle", 3'd2, 4'd3, 4'd12, 4'h0, 4'h0, 8'd0);

    // Inverted threshold pair is ignored
    bus.sInit = 1'b1;
    step("re_init", 3'd1, 4'd3, 4'd12, 4'h0, 4'h0, 8'd0);
    bus.sThreshLow = 4'd9; bus.sThreshHigh = 4'd5;
    step("bad_thr", 3'd1, 4'd3, 4'd12, 4'h0, 4'h0, 8'd0);
    bus.sInit = 1'b0;
    step("bad_thr_x", 3'd2, 4'd3, 4'd12, 4'h0, 4'h0, 8'd0);
    bus.sThreshLow = 4'd3; bus.sThreshHigh = 4'd12;

    // Pause / resume
    bus.sEmpty = 4'h0;
    step("to_act", 3'd3, 4'd3, 4'd12, 4'h0, 4'h0, 8'd0);
    bus.sPause = 4'b0110;
    step("pause", 3'd4, 4'd3, 4'd12, 4'b0110, 4'h0, 8'd0);
    bus.sPause = 4'b0000; bus.sContinue = 4'b0010;
    step("resume1", 3'd4, 4'd3, 4'd12, 4'b0100, 4'h0, 8'd0);
    bus.sContinue = 4'b0100;
    step("resume2", 3'd3, 4'd3, 4'd12, 4'b0000, 4'h0, 8'd0);
    bus.sContinue = 4'b0000;

    // Continue wins over pause on the same bit
    bus.sPause = 4'b0001;
    step("pause1", 3'd4, 4'd3, 4'd12, 4'b0001, 4'h0, 8'd0);
    bus.sPause = 4'b1000; bus.sContinue = 4'b1001;
    step("simult", 3'd3, 4'd3, 4'd12, 4'b0000, 4'h0, 8'd0);
    bus.sPause = 4'b0000; bus.sContinue = 4'b0000;

    // Empty rule
    bus.sEmpty = 4'hF;
    step("act_idle", 3'd2, 4'd3, 4'd12, 4'h0, 4'h0, 8'd0);
    bus.sEmpty = 4'h0;
    step("idle_act", 3'd3, 4'd3, 4'd12, 4'h0, 4'h0, 8'd0);

    // Error has priority over init and pause
    bus.sFull = 4'd4; bus.sInit = 1'b1; bus.sPause = 4'hF;
    step("err_ent", 3'd5, 4'd3, 4'd12, 4'h0, 4'b0100, 8'd1);
    bus.sFull = 4'hB; bus.sInit = 1'b0; bus.sPause = 4'h0;
    step("err_hold", 3'd5, 4'd3, 4'd12, 4'h0, 4'b0100, 8'd1);
    bus.sFull = 4'h0; bus.sInit = 1'b1;
`ifdef FSM_ERR_RECOVER_EN
    step("err_rec", 3'd1, 4'd3, 4'd12, 4'h0, 4'h0, 8'd1);
`else
    step("err_stick", 3'd5, 4'd3, 4'd12, 4'h0, 4'b0100, 8'd1);
`endif

    // Async reset between edges, then climb back to PAUSE and abort again
    #2 sReset = 1'b0;
    #1 check_reset_values("rst_async1");
    #3 sReset = 1'b1;
    bus.sInit = 1'b1; bus.sEmpty = 4'hF;
    step("rb_init", 3'd1, 4'd1, 4'd14, 4'h0, 4'h0, 8'd0);
    bus.sInit = 1'b0;
    step("rb_idle", 3'd2, 4'd3, 4'd12, 4'h0, 4'h0, 8'd0);
    bus.sEmpty = 4'h0;
    step("rb_act", 3'd3, 4'd3, 4'd12, 4'h0, 4'h0, 8'd0);
    bus.sPause = 4'b0011;
    step("rb_pause", 3'd4, 4'd3, 4'd12, 4'b0011, 4'h0, 8'd0);
    #2 sReset = 1'b0;
    #1 check_reset_values("rst_mid_pause");
    @(posedge CLK);
    #1 check_reset_values("rst_held");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fsm_flow_ctrl_n.md
Name: fsm_flow_ctrl_n

Overview:
Parametrised successor of the 4-channel FIFO flow-control FSM. Supervises N_CH FIFO channels through RESET/INIT/IDLE/ACTIVE/PAUSE/ERROR states, with per-channel pause tracking. Latches low/high watermark thresholds during INIT. Records which channels caused an overflow error. Sits between the FIFO bank (status flags) and the datapath arbiter (consumes state/threshold outputs).

Parameters:
N_CH, 4, number of supervised FIFO channels (1..16)
TW, 4, watermark threshold width in bits
LOW_DEF, 1, reset value of oThreshLow
HIGH_DEF, 14, reset value of oThreshHigh

Ports:
CLK  input  1  system clock, rising edge
sReset  input  1  asynchronous active-low reset
sInit  input  1  request INIT (threshold load) state
sEmpty  input  N_CH  per-channel FIFO empty flags
sFull  input  N_CH  per-channel FIFO full flags
sPause  input  N_CH  per-channel pause requests
sContinue  input  N_CH  per-channel resume requests
sThreshLow  input  TW  low watermark, sampled in INIT
sThreshHigh  input  TW  high watermark, sampled in INIT
oState  output  3  state code: RESET=0 INIT=1 IDLE=2 ACTIVE=3 PAUSE=4 ERROR=5
oThreshLow  output  TW  latched low watermark
oThreshHigh  output  TW  latched high watermark
oPauseMask  output  N_CH  channels currently paused
oErrChan  output  N_CH  sFull mask captured on ERROR entry
oIdle  output  1  high while in IDLE
oError  output  1  high while in ERROR

Behaviour:
- Reset: sReset=0 forces, asynchronously, oState=RESET, oThreshLow=LOW_DEF, oThreshHigh=HIGH_DEF, oPauseMask=0, oErrChan=0, oIdle=0, oError=0.
- All outputs are registered. Inputs sampled at rising edge k are reflected on the outputs after edge k (1-cycle latency). oIdle and oError are decoded from the next state, so they align with oState.
- RESET: first edge with sReset=1 -> INIT, unconditionally.
- INIT: thresholds load from sThreshLow/sThreshHigh every cycle spent in INIT.
  - sInit=0 -> IDLE; otherwise stay.
  - If sThreshLow > sThreshHigh, the pair is not loaded; previous values are kept.
- Transition priority in IDLE/ACTIVE/PAUSE (highest first):
  - (|sFull) -> ERROR
  - sInit -> INIT
  - pause rule
  - empty rule
- IDLE: (&sEmpty)=0 -> ACTIVE; else stay.
- ACTIVE:
  - nm = sPause & ~sContinue.
  - nm!=0 -> PAUSE, oPauseMask<=nm.
  - else (&sEmpty)=1 -> IDLE.
  - else stay.
- PAUSE:
  - nm = (oPauseMask | sPause) & ~sContinue. sContinue wins over sPause on the same bit.
  - nm==0 -> ACTIVE; else stay, oPauseMask<=nm.
  - sEmpty is ignored in PAUSE.
- oPauseMask is cleared on any transition into INIT, IDLE, or ERROR.
- ERROR entry: oErrChan<=sFull (the mask at the entry edge). Mask is not updated while in ERROR.
- ERROR is sticky. It exits only via sReset=0 (see optional feature). sInit, sFull, and the other inputs are ignored in ERROR.
- Reset mid-operation: an asynchronous abort from any state. No partial state is preserved.
- N_CH=1: the reductions collapse to single bits; behaviour is unchanged.

Optional Feature:
FSM_ERR_RECOVER_EN
- Defined:
  - In ERROR, sInit=1 at an edge -> INIT and clears oErrChan.
  - Adds output oErrCnt [7:0]: increments on each ERROR entry, saturates at 255, reset to 0.
- Undefined:
  - ERROR exits only by reset.
  - oErrCnt port is absent.

Decomposition:
- Package fsm_flow_pkg:
  - state localparams ST_RESET..ST_ERROR (3-bit)
  - ERR_CNT_W=8
- One sub-module, fsm_pause_tracker (parameter N_CH):
  - Inputs: current state, sPause, sContinue.
  - Computes nm and holds the oPauseMask register.
  - Asserts any_paused.
- The top-level FSM owns the state register, threshold registers, and error capture.

Test Plan:
- Bring-up: sReset=0 for 14 time units, sInit=1, sThreshLow=3, sThreshHigh=12; release sReset. Required sequence: oState 0 -> 1. Then sInit=0, sEmpty=4'hF -> oState=2, oIdle=1, oThreshLow=3, oThreshHigh=12.
- Invalid thresholds: in INIT apply sThreshLow=9, sThreshHigh=5 -> thresholds keep their previous values (3/12).
- Pause/resume: in ACTIVE (sEmpty=0), sPause=4'b0110 -> oState=4, oPauseMask=4'b0110.
  - Then sPause=0, sContinue=4'b0010 -> mask 4'b0100, stay PAUSE.
  - Then sContinue=4'b0100 -> oState=3, mask 0.
- Simultaneous events: in PAUSE with mask 4'b0001, drive sPause=4'b1000, sContinue=4'b1001 in the same cycle -> mask 0, oState=3.
- Error priority: in ACTIVE, sFull=4'd4, sInit=1, sPause=4'hF in the same cycle -> oState=5, oError=1, oErrChan=4'b0100.
  - Later sFull=0, sInit=1 -> stays ERROR (macro undefined).
  - With FSM_ERR_RECOVER_EN defined -> oState=1, oErrChan=0, oErrCnt=1.
- Reset mid-PAUSE: assert sReset=0 between clock edges -> oState=0 and all outputs at reset values immediately, before the next CLK edge.
